// File: rtl/instr_queue.sv
// instr_queue
// Circular instruction buffer: {opcode, operand_a, operand_b} entries with
// internally managed head/tail pointers. Both sides use valid/ready handshakes.
// The head is first-word-fall-through, and an indexed peek port reads relative
// to the head.
//
// Ports
//   clk, reset_n         clock, async active-low reset
//   wr_valid/wr_ready    producer handshake; wr_opcode/operand_a/operand_b data
//   rd_valid/rd_ready    consumer handshake; rd_opcode/operand_a/operand_b head
//   peek_index           offset from head; peek_valid/peek_* entry at head+index
//   flush                synchronous clear of contents and sticky flags
//   count, full, empty   occupancy status (registered / derived from registers)
//   overflow, underflow  sticky error flags (push when full / pop when empty)
module instr_queue #(
  parameter int DEPTH = 32,
  parameter int OPW   = 32,
  parameter int OPCW  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [OPCW-1:0]          wr_opcode,
  input  logic [OPW-1:0]           wr_operand_a,
  input  logic [OPW-1:0]           wr_operand_b,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [OPCW-1:0]          rd_opcode,
  output logic [OPW-1:0]           rd_operand_a,
  output logic [OPW-1:0]           rd_operand_b,
  input  logic [$clog2(DEPTH)-1:0] peek_index,
  output logic                     peek_valid,
  output logic [OPCW-1:0]          peek_opcode,
  output logic [OPW-1:0]           peek_operand_a,
  output logic [OPW-1:0]           peek_operand_b,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [OPCW-1:0] opc;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
  } instr_t;

  instr_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, peek_ptr;
  logic [AW:0]   count_q;
  logic          ovf_q, udf_q;
  logic          push, pop;
  instr_t        head, peek;

  // Status is derived purely from registered occupancy.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign underflow = udf_q;

  // Ready depends on state only: a same-cycle pop never frees room for a push.
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign push     = wr_valid && !full;
  assign pop      = rd_ready && !empty;

  // Head and peek reads; empty / out-of-range slots read as ZERO/0.
  assign peek_ptr   = rd_ptr + peek_index;
  assign peek_valid = ({1'b0, peek_index} < count_q);
  assign head       = empty      ? '0 : mem[rd_ptr];
  assign peek       = peek_valid ? mem[peek_ptr] : '0;

  assign rd_opcode      = head.opc;
  assign rd_operand_a   = head.a;
  assign rd_operand_b   = head.b;
  assign peek_opcode    = peek.opc;
  assign peek_operand_a = peek.a;
  assign peek_operand_b = peek.b;

  // Entry storage; reset clears every slot, flush leaves contents alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= '{opc: wr_opcode, a: wr_operand_a, b: wr_operand_b};
    end
  end

  // Pointers, occupancy and sticky flags. Flush wins over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_valid && full)  ovf_q <= 1'b1;
      if (rd_ready && empty) udf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue (DEPTH=32, OPW=32, OPCW=4).
module tb_instr_queue;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_opcode;
  logic [31:0] wr_operand_a, wr_operand_b;
  logic        rd_valid, rd_ready;
  logic [3:0]  rd_opcode;
  logic [31:0] rd_operand_a, rd_operand_b;
  logic [4:0]  peek_index;
  logic        peek_valid;
  logic [3:0]  peek_opcode;
  logic [31:0] peek_operand_a, peek_operand_b;
  logic        flush;
  logic [5:0]  count;
  logic        full, empty, overflow, underflow;

  instr_queue #(.DEPTH(DEPTH), .OPW(32), .OPCW(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_opcode(wr_opcode),
    .wr_operand_a(wr_operand_a), .wr_operand_b(wr_operand_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_opcode(rd_opcode),
    .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
    .peek_index(peek_index), .peek_valid(peek_valid), .peek_opcode(peek_opcode),
    .peek_operand_a(peek_operand_a), .peek_operand_b(peek_operand_b),
    .flush(flush), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [67:0] sb[$];
  bit          m_ovf, m_udf;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_status();
    chk("count", 72'(count), 72'(sb.size()));
    chk("full", 72'(full), 72'(sb.size() == DEPTH));
    chk("empty", 72'(empty), 72'(sb.size() == 0));
    chk("overflow", 72'(overflow), 72'(m_ovf));
    chk("underflow", 72'(underflow), 72'(m_udf));
  endtask

  // One cycle: drive request, check handshake/head before the edge, status after.
  task automatic xfer(input bit w, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit r);
    bit full_m, empty_m;
    logic [67:0] e;
    full_m  = (sb.size() == DEPTH);
    empty_m = (sb.size() == 0);
    wr_valid = w; wr_opcode = o; wr_operand_a = a; wr_operand_b = b; rd_ready = r;
    #1;
    chk("wr_ready", 72'(wr_ready), 72'(!full_m));
    chk("rd_valid", 72'(rd_valid), 72'(!empty_m));
    if (r && !empty_m) begin
      e = sb.pop_front();
      chk("rd_data", 72'({rd_opcode, rd_operand_a, rd_operand_b}), 72'(e));
    end
    if (w && full_m)  m_ovf = 1'b1;
    if (r && empty_m) m_udf = 1'b1;
    if (w && !full_m) sb.push_back({o, a, b});
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk_status();
  endtask

  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    wr_opcode = '0; wr_operand_a = '0; wr_operand_b = '0; peek_index = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    // Reset values
    chk("rst_wr_ready", 72'(wr_ready), 72'(1));
    chk("rst_rd_valid", 72'(rd_valid), 72'(0));
    chk("rst_peek_valid", 72'(peek_valid), 72'(0));
    chk("rst_rd_data", 72'({rd_opcode, rd_operand_a, rd_operand_b}), 72'(0));
    chk("rst_peek_data", 72'({peek_opcode, peek_operand_a, peek_operand_b}), 72'(0));
    chk_status();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-burst with 5 entries queued
    for (int i = 0; i < 5; i++) xfer(1'b1, 4'(i + 2), 32'(100 + i), 32'(i), 1'b0);
    wr_valid = 1'b1; wr_opcode = 4'h9; wr_operand_a = 32'd55; wr_operand_b = 32'd66;
    #2 reset_n = 1'b0;
    #1;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    chk("arst_rd_valid", 72'(rd_valid), 72'(0));
    chk("arst_rd_opcode", 72'(rd_opcode), 72'(0));
    chk_status();
    @(posedge clk); #1;
    chk_status();
    wr_valid = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 4'h1, 32'd7, 32'd3, 1'b0);  // ADD 7,3
    chk("post_rst_rd_valid", 72'(rd_valid), 72'(1));
    chk("post_rst_head", 72'({rd_opcode, rd_operand_a, rd_operand_b}), 72'({4'h1, 32'd7, 32'd3}));
    xfer(1'b0, '0, '0, '0, 1'b1);

    // Fill to full, then overflow attempt
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, 4'(i), 32'(i), ~32'(i), 1'b0);
    xfer(1'b1, 4'hf, 32'hdead, 32'hbeef, 1'b0);
    chk("ovf_head_a", 72'(rd_operand_a), 72'(0));

    // Drain in order, then underflow attempt
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, '0, '0, '0, 1'b1);
    xfer(1'b0, '0, '0, '0, 1'b1);

    // Wrap-around: pointers pass DEPTH-1
    for (int i = 0; i < 20; i++) xfer(1'b1, 4'(i), 32'(200 + i), 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) xfer(1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 20; i++) xfer(1'b1, 4'(i + 3), 32'(300 + i), 32'(-i), 1'b0);
    chk("wrap_count", 72'(count), 72'(20));
    for (int i = 0; i < 20; i++) xfer(1'b0, '0, '0, '0, 1'b1);

    // Sustained simultaneous push+pop at count=10
    for (int i = 0; i < 10; i++) xfer(1'b1, 4'(i), 32'(400 + i), 32'($urandom), 1'b0);
    for (int i = 0; i < 50; i++) xfer(1'b1, 4'($urandom), 32'(500 + i), 32'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) xfer(1'b0, '0, '0, '0, 1'b1);

    // Peek
    for (int i = 1; i <= 4; i++) xfer(1'b1, 4'(i), 32'(10 * i), 32'(i), 1'b0);
    peek_index = 5'd2; #1;
    chk("peek2_valid", 72'(peek_valid), 72'(1));
    chk("peek2_data", 72'({peek_opcode, peek_operand_a, peek_operand_b}), 72'({4'd3, 32'd30, 32'd3}));
    peek_index = 5'd0; #1;
    chk("peek0_a", 72'(peek_operand_a), 72'(10));
    peek_index = 5'd4; #1;
    chk("peek4_valid", 72'(peek_valid), 72'(0));
    chk("peek4_data", 72'({peek_opcode, peek_operand_a, peek_operand_b}), 72'(0));

    // Flush with a concurrent push: flush wins, sticky flags clear
    flush = 1'b1; wr_valid = 1'b1; wr_opcode = 4'h5; wr_operand_a = 32'd99; wr_operand_b = 32'd98;
    @(posedge clk); #1;
    flush = 1'b0; wr_valid = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    chk("flush_rd_valid", 72'(rd_valid), 72'(0));
    chk_status();
    xfer(1'b0, '0, '0, '0, 1'b0);
    xfer(1'b1, 4'h2, 32'd77, 32'd88, 1'b0);
    xfer(1'b0, '0, '0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
